// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multi-cycle multiply/divide sequencer (shift-add / restoring shift-subtract)
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and zero-dividend divides in one cycle.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  busy_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_funct3;
    logic            r_neg;
    logic [W-1:0]    r_opnd;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_result;

    logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [W-1:0]    w_a_mag, w_b_mag, w_special_val, w_final, w_quo, w_rem;
    logic            w_div_zero, w_overflow, w_early, w_special, w_last;
    logic [W:0]      w_mul_sum, w_rem_sh, w_diff;
    logic [2*W-1:0]  w_mul_next, w_div_next, w_acc_next, w_prod;

    assign w_is_div   = funct3_i[2];
    assign w_a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_a_neg    = w_a_signed && rs1_data_i[W-1];
    assign w_b_neg    = w_b_signed && rs2_data_i[W-1];
    assign w_a_mag    = w_a_neg ? -rs1_data_i : rs1_data_i;
    assign w_b_mag    = w_b_neg ? -rs2_data_i : rs2_data_i;

    assign w_div_zero = w_is_div && (rs2_data_i == '0);
    assign w_overflow = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                        (rs1_data_i == {1'b1, {(W-1){1'b0}}}) && (rs2_data_i == {W{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early    = (!w_is_div && ((rs1_data_i == '0) || (rs2_data_i == '0))) ||
                        (w_is_div && (rs1_data_i == '0) && (rs2_data_i != '0));
`else
    assign w_early    = 1'b0;
`endif
    assign w_special  = w_div_zero || w_overflow || w_early;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU in the divide group
    always_comb begin
        w_special_val = '0;
        if (w_div_zero)
            w_special_val = funct3_i[1] ? rs1_data_i : {W{1'b1}};
        else if (w_overflow)
            w_special_val = funct3_i[1] ? {W{1'b0}} : rs1_data_i;
    end

    // Multiply: product high half accumulates in acc[2W-1:W], multiplier shifts out of acc[W-1:0]
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: remainder in acc[2W-1:W], quotient bits shift into acc[0]; diff[W] is the borrow
    assign w_rem_sh   = r_acc[2*W-1:W-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = {(w_diff[W] ? w_rem_sh[W-1:0] : w_diff[W-1:0]), r_acc[W-2:0], ~w_diff[W]};

    assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;
    assign w_last     = (r_count == CW'(W-1));

    always_comb begin
        w_prod = r_neg ? -w_acc_next : w_acc_next;
        w_quo  = r_neg ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
        w_rem  = r_neg ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];
        case (r_funct3)
            3'b000:                 w_final = w_prod[W-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*W-1:W];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_funct3 <= funct3_i;
                        r_count  <= '0;
                        r_neg    <= (w_is_div && funct3_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc    <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        if (w_special)
                            r_result <= w_special_val;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (w_last)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state == S_CALC);
    assign done_o   = (r_state == S_DONE);
    assign stall_o  = start_i && (r_state != S_DONE);
    assign result_o = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] corner [5];

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f3)
            3'd0: p = ua * ub;
            3'd1: p = {32'd0, 32'(($unsigned(sa * sb)) >> 32)};
            3'd2: p = {32'd0, 32'(($unsigned(sa * longint'(ub))) >> 32)};
            3'd3: p = {32'd0, 32'((ua * ub) >> 32)};
            3'd4: p = (b == 0) ? 64'hFFFF_FFFF : 64'(sa / sb);
            3'd5: p = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
            3'd6: p = (b == 0) ? {32'd0, a} : 64'(sa % sb);
            default: p = (b == 0) ? {32'd0, a} : 64'(ua % ub);
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2] && (a == 0 || b == 0)) return 1;
        if (f3[2] && a == 0) return 1;
`endif
        return 33;
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge one idle cycle after done
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int exp_lat, cyc, stall_bad, busy_bad;
        bit seen;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b;
        cyc = 0; seen = 0; stall_bad = 0; busy_bad = 0;
        #1;
        if (stall_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) stall_bad++;
        while (!seen && cyc < 100) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (done_o === 1'b1) begin
                seen = 1;
                if (stall_o !== 1'b0 || busy_o !== 1'b0) stall_bad++;
            end else begin
                if (stall_o !== 1'b1) stall_bad++;
                if (busy_o !== 1'b1) busy_bad++;
                rs1_data_i = $urandom; rs2_data_i = $urandom; funct3_i = 3'($urandom);
            end
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_result"}, {32'd0, result_o}, {32'd0, exp_res});
        check_eq({tag, "_stall_busy"}, 64'(stall_bad + busy_bad), 64'd0);
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq({tag, "_hold"}, {31'd0, done_o, result_o}, {32'd0, exp_res});
    endtask

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300)) - 32'd150;
        return $urandom;
    endfunction

    initial begin
        int n_done;
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
        reset = 1'b1; start_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", {29'd0, busy_o, done_o, stall_o, result_o}, 64'd0);
        reset = 1'b0;

        run_op("mul_7x-3",     3'd0, 32'd7,        32'hFFFF_FFFD);
        run_op("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_-7_2",     3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_-7_2",     3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7);
        run_op("divu_5_0",     3'd5, 32'd5,        32'd0);
        run_op("rem_5_0",      3'd6, 32'd5,        32'd0);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mul_zero",     3'd0, 32'h1234,     32'd0);
        run_op("div_zero_dvd", 3'd4, 32'd0,        32'd9);
        run_op("mul_pre_rst",  3'd0, 32'd11,       32'd13);

        // Reset in the middle of a calculation
        start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd6;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        check_eq("busy_before_rst", {63'd0, busy_o}, 64'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("after_rst", {30'd0, busy_o, done_o, result_o}, 64'd0);
        reset = 1'b0; start_i = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (done_o === 1'b1) n_done++;
        end
        check_eq("no_done_after_rst", 64'(n_done), 64'd0);
        run_op("mul_after_rst", 3'd0, 32'd5, 32'd6);

        // Back-to-back with start held: MUL 3x4 then DIVU 12/5
        start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd4;
        n_done = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); @(negedge clk);
            if (done_o === 1'b1) begin
                if (n_done == 0) begin
                    check_eq("b2b_done1_cycle", 64'(c), 64'd33);
                    check_eq("b2b_result1", {32'd0, result_o}, 64'd12);
                    check_eq("b2b_stall_in_done", {63'd0, stall_o}, 64'd0);
                    funct3_i = 3'd5; rs1_data_i = 32'd12; rs2_data_i = 32'd5;
                end else if (n_done == 1) begin
                    check_eq("b2b_done2_cycle", 64'(c), 64'd67);
                    check_eq("b2b_result2", {32'd0, result_o}, 64'd2);
                    start_i = 1'b0;
                end
                n_done++;
            end
        end
        check_eq("b2b_done_count", 64'(n_done), 64'd2);
        start_i = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
